// File: rtl/spinner_multi_if.sv
// Handshake-free bundle between the INPx mux and the multi-channel spinner:
// frame strobe, per-channel controls and analog deltas in, positions out.
interface spinner_multi_if #(
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 8
);
  logic                      strobe;
  logic [CHANNELS-1:0]       minus;
  logic [CHANNELS-1:0]       plus;
  logic [CHANNELS-1:0]       fast;
  logic [CHANNELS-1:0]       invert;
  logic [9*CHANNELS-1:0]     spin_in;
  logic [9*CHANNELS-1:0]     mouse_in;
  logic [OUT_W*CHANNELS-1:0] spin_out;
  logic [CHANNELS-1:0]       moving;
  logic [CHANNELS-1:0]       src_mouse;

  modport master (
    output strobe, minus, plus, fast, invert, spin_in, mouse_in,
    input  spin_out, moving, src_mouse
  );

  modport slave (
    input  strobe, minus, plus, fast, invert, spin_in, mouse_in,
    output spin_out, moving, src_mouse
  );
endinterface

// File: rtl/spinner_multi.sv
// Multi-channel rotary encoder: buttons, spinner and mouse deltas folded into
// one wrapping position per channel, advanced once per frame strobe edge.
module spinner_multi #(
  parameter int CHANNELS    = 2,
  parameter int OUT_W       = 8,
  parameter int STEP_SLOW   = 2,
  parameter int STEP_FAST   = 6,
  parameter int ACCEL_TICKS = 16,
  parameter int MAX_STEP    = 32,
  parameter int PEND_MAX    = 255
) (
  input logic             clk,
  input logic             reset,
  spinner_multi_if.slave  bus
);
  localparam int PW = $clog2(PEND_MAX + 1) + 1;
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  // Working width covers pending - clamp + two event deltas without overflow.
  localparam int CW = (PW + 3 > OUT_W) ? PW + 3 : OUT_W + 1;
  localparam logic signed [CW-1:0] PMAX = CW'(PEND_MAX);
  localparam logic signed [CW-1:0] SMAX = CW'(MAX_STEP);

  function automatic logic signed [CW-1:0] sext8(input logic [7:0] v);
    return {{(CW-8){v[7]}}, v};
  endfunction

  function automatic logic signed [CW-1:0] sext_pend(input logic signed [PW-1:0] p);
    return {{(CW-PW){p[PW-1]}}, p};
  endfunction

  function automatic logic signed [PW-1:0] sat_pend(input logic signed [CW-1:0] v);
    if (v > PMAX)       return PW'(PMAX);
    else if (v < -PMAX) return PW'(-PMAX);
    else                return PW'(v);
  endfunction

  function automatic logic signed [CW-1:0] clamp_step(input logic signed [CW-1:0] p);
    if (p > SMAX)       return SMAX;
    else if (p < -SMAX) return -SMAX;
    else                return p;
  endfunction

  logic                      strobe_r;
  logic                      tick;
  logic [OUT_W-1:0]          pos_r    [CHANNELS];
  logic signed [PW-1:0]      pend_r   [CHANNELS];
  logic [HW-1:0]             hold_r   [CHANNELS];
  logic [CHANNELS-1:0]       up_r, dn_r, spin_tg_r, mouse_tg_r, moving_r, src_r;

  logic [OUT_W-1:0]          pos_nx   [CHANNELS];
  logic signed [PW-1:0]      pend_nx  [CHANNELS];
  logic [HW-1:0]             hold_nx  [CHANNELS];
  logic [CHANNELS-1:0]       up_w, dn_w, spin_ev, mouse_ev;

  assign tick = bus.strobe & ~strobe_r;

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      logic signed [CW-1:0] ev_sum, pend_w, a, step, d, total;
      spin_ev[n]  = bus.spin_in[9*n+8]  != spin_tg_r[n];
      mouse_ev[n] = bus.mouse_in[9*n+8] != mouse_tg_r[n];
      ev_sum = (spin_ev[n]  ? sext8(bus.spin_in[9*n +: 8])  : '0)
             + (mouse_ev[n] ? sext8(bus.mouse_in[9*n +: 8]) : '0);
      pend_w      = sext_pend(pend_r[n]);
      a           = tick ? clamp_step(pend_w) : '0;
      pend_nx[n]  = sat_pend(pend_w - a + ev_sum);
      up_w[n]     = bus.plus[n] & ~bus.minus[n];
      dn_w[n]     = bus.minus[n] & ~bus.plus[n];
      step        = bus.fast[n] ? CW'(STEP_FAST) : CW'(STEP_SLOW);
      // Acceleration keys off the hold count from before this tick.
      if (hold_r[n] == HW'(ACCEL_TICKS)) step = step + step;
      d           = up_w[n] ? step : (dn_w[n] ? -step : '0);
      total       = d + a;
      if (bus.invert[n]) total = -total;
      pos_nx[n]   = pos_r[n] + total[OUT_W-1:0];
      if ((up_w[n] && up_r[n]) || (dn_w[n] && dn_r[n]))
        hold_nx[n] = (hold_r[n] == HW'(ACCEL_TICKS)) ? hold_r[n] : hold_r[n] + 1'b1;
      else
        hold_nx[n] = (up_w[n] | dn_w[n]) ? HW'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_r <= 1'b1;
      up_r     <= '0;
      dn_r     <= '0;
      moving_r <= '0;
      src_r    <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        pos_r[n]      <= '0;
        pend_r[n]     <= '0;
        hold_r[n]     <= '0;
        spin_tg_r[n]  <= bus.spin_in[9*n+8];
        mouse_tg_r[n] <= bus.mouse_in[9*n+8];
      end
    end else begin
      strobe_r <= bus.strobe;
      for (int n = 0; n < CHANNELS; n++) begin
        pend_r[n]     <= pend_nx[n];
        spin_tg_r[n]  <= bus.spin_in[9*n+8];
        mouse_tg_r[n] <= bus.mouse_in[9*n+8];
        moving_r[n]   <= (pend_nx[n] != '0) | (bus.plus[n] ^ bus.minus[n]);
        if (spin_ev[n])       src_r[n] <= 1'b0;
        else if (mouse_ev[n]) src_r[n] <= 1'b1;
        if (tick) begin
          pos_r[n]  <= pos_nx[n];
          hold_r[n] <= hold_nx[n];
          up_r[n]   <= up_w[n];
          dn_r[n]   <= dn_w[n];
        end
      end
    end
  end

  always_comb begin
    bus.spin_out = '0;
    for (int n = 0; n < CHANNELS; n++) bus.spin_out[n*OUT_W +: OUT_W] = pos_r[n];
  end
  assign bus.moving    = moving_r;
  assign bus.src_mouse = src_r;
endmodule
